life_controller: RTL and testbench
==================================

Name: life_controller

Overview:
- Sequences the player's life resource across death, respawn, invulnerability and game-over.
- Owns the spare-life count and drives the life-icon bitmap mask on the HUD.
- Arbitrates between collision hits (monster or falling bag) and bonus-life grants from the score logic.
- Freezes gameplay during the death animation and raises game_over once the last life is used.

Parameters:
START_LIVES, 3, spare lives loaded at reset and at game start (1..MAX_LIVES)
MAX_LIVES, 3, saturation ceiling; width of lives_mask
DEATH_FRAMES, 90, frames spent in DYING (death animation, world frozen)
INVULN_FRAMES, 120, frames after respawn during which hits are ignored

Ports:
clk  in  1  system clock
resetN  in  1  reset, asynchronous, active-low
startOfFrame  in  1  one-cycle pulse per video frame; all timing counts these pulses
playGame  in  1  level; a rising edge starts or restarts a game
hit  in  1  one-cycle pulse: player collided with a lethal object
bonus_life  in  1  one-cycle pulse: score crossed a bonus threshold
lives_mask  out  MAX_LIVES  bit i = 1 iff i < lives (LSB-first thermometer), to the HUD bitmap
life_lost  out  1  one-cycle pulse on every accepted hit
respawn  out  1  one-cycle pulse; player and monsters return to start positions
freeze  out  1  high in DYING; gameplay movers hold position
invulnerable  out  1  high in INVULN; player sprite blinks
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (async, resetN=0):
  - State goes to IDLE; lives=START_LIVES; frame counter=0.
  - All pulses, freeze, invulnerable and game_over are 0.
  - lives_mask reflects START_LIVES.
- playGame edge detection: a registered copy of playGame detects the rising edge. The registered copy resets to 0, so playGame held high through reset counts as an edge on the first cycle.
- States (transitions are registered):
  - IDLE: on a playGame rising edge, set lives=START_LIVES and go to RESPAWN.
  - RESPAWN: lasts exactly one cycle with respawn=1; clear the frame counter; go to INVULN.
  - INVULN: invulnerable=1.
    - hit is ignored.
    - Counter increments on startOfFrame.
    - When the counter reaches INVULN_FRAMES-1 and startOfFrame=1, go to ALIVE.
  - ALIVE: on hit, pulse life_lost for one cycle, clear the counter and go to DYING.
    - If lives>0, lives decrements in the same cycle.
    - If lives==0, lives stays 0 and an internal last_life flag is set.
  - DYING: freeze=1; hit is ignored; counter counts startOfFrame.
    - After DEATH_FRAMES frames: go to GAME_OVER if last_life, otherwise to RESPAWN.
  - GAME_OVER: game_over=1; hit and bonus_life are ignored.
    - A playGame rising edge clears last_life, reloads START_LIVES and goes to RESPAWN.
- bonus_life:
  - Accepted in RESPAWN, INVULN, ALIVE and DYING.
  - lives = min(lives+1, MAX_LIVES); it saturates silently.
  - Ignored in IDLE and GAME_OVER.
  - If accepted in DYING while last_life=1, last_life clears and the next transition is RESPAWN.
- hit and bonus_life in the same ALIVE cycle: the hit is applied first, then the bonus.
  - Example, lives=1: result is lives=1, DYING, life_lost=1.
  - Example, lives=0: last_life is set and then immediately cleared by the bonus, so lives=0 and the next transition is RESPAWN.
- A startOfFrame arriving in the same cycle as the state entry is not counted.
- Each timed state therefore lasts exactly N full startOfFrame pulses after entry.
- playGame falling edge: no effect.
- Width rules:
  - Counter width = $clog2(max(DEATH_FRAMES, INVULN_FRAMES)+1).
  - lives width = $clog2(MAX_LIVES+1).
  - No wrap-around is permitted.
- Latency: life_lost and lives_mask update on the clock edge after hit is sampled (1 cycle).

Decomposition:
- Shared game package holds:
  - enum life_state_t {IDLE, RESPAWN, INVULN, ALIVE, DYING, GAME_OVER};
  - MAX_LIVES and START_LIVES defaults;
  - the function lives_to_mask(lives), which the HUD bitmap also uses.
- Sub-module frame_timer: counter cleared by clr, incremented on startOfFrame, flags done at a parameterised terminal count. It is instantiated once and shared by INVULN and DYING.

Test Plan:
(Parameters for all scenarios: START=3, MAX=3, DEATH=4, INVULN=3.)
- Reset, then a playGame rise → respawn pulse 1 cycle later; invulnerable for 3 frames; ALIVE; lives_mask=3'b111.
- In ALIVE, hit → life_lost 1 cycle; lives_mask=3'b011; freeze for 4 frames; respawn; invulnerable.
- hit during INVULN and during DYING → no life_lost; mask unchanged.
- Four accepted hits from 3 lives → masks 011, 001, 000; after the 4th DYING, game_over=1; a playGame rise restores 111 and respawn.
- bonus_life at lives=3 → stays 111. Simultaneous hit+bonus at lives=1 → mask 001; DYING entered.
- Assert resetN low mid-DYING → freeze=0 and state IDLE immediately (async); mask 111; no pulses until the next playGame rise.

Source files
------------

// File: rtl/life_controller_pkg.sv
// Shared game definitions: life FSM states, default life counts, HUD mask helper.
// Pure declarations; no logic or timing of its own.
package life_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESPAWN,
    INVULN,
    ALIVE,
    DYING,
    GAME_OVER
  } life_state_t;

  localparam int DFLT_START_LIVES   = 3;
  localparam int DFLT_MAX_LIVES     = 3;
  localparam int DFLT_DEATH_FRAMES  = 90;
  localparam int DFLT_INVULN_FRAMES = 120;

  // LSB-first thermometer: bit i set iff i < lives; callers size-cast to their icon count.
  function automatic logic [31:0] lives_to_mask(input int lives);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i < lives);
    end
    return m;
  endfunction

endpackage

// File: rtl/life_controller_if.sv
// Game-logic <-> life controller signal bundle; master is the game side, slave the controller.
// Single-cycle pulses and levels only; no backpressure.
interface life_controller_if
  import life_controller_pkg::*;
#(
  parameter int MAX_LIVES = DFLT_MAX_LIVES
);

  logic                 startOfFrame;
  logic                 playGame;
  logic                 hit;
  logic                 bonus_life;
  logic [MAX_LIVES-1:0] lives_mask;
  logic                 life_lost;
  logic                 respawn;
  logic                 freeze;
  logic                 invulnerable;
  logic                 game_over;

  modport master (
    output startOfFrame, playGame, hit, bonus_life,
    input  lives_mask, life_lost, respawn, freeze, invulnerable, game_over
  );

  modport slave (
    input  startOfFrame, playGame, hit, bonus_life,
    output lives_mask, life_lost, respawn, freeze, invulnerable, game_over
  );

endinterface

// File: rtl/life_controller_frame_timer.sv
// Frame-pulse counter shared by the timed states; done is combinational on the terminal tick.
// Counter saturates at the terminal value so it can never wrap; clr has priority over tick.
module life_controller_frame_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // The terminal value is an input because INVULN and DYING use different lengths.
  assign done = tick && (count == last);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (tick && (count != last)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/life_controller.sv
// Player life sequencer: death/respawn/invulnerability/game-over FSM plus spare-life count.
// All outputs registered; life_lost and lives_mask update one cycle after hit. No backpressure.
module life_controller
  import life_controller_pkg::*;
#(
  parameter int START_LIVES   = DFLT_START_LIVES,
  parameter int MAX_LIVES     = DFLT_MAX_LIVES,
  parameter int DEATH_FRAMES  = DFLT_DEATH_FRAMES,
  parameter int INVULN_FRAMES = DFLT_INVULN_FRAMES
) (
  input logic              clk,
  input logic              resetN,
  life_controller_if.slave bus
);

  localparam int LW = $clog2(MAX_LIVES + 1);
  localparam int CW = $clog2(((DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES) + 1);

  localparam logic [LW-1:0] START_L     = LW'(START_LIVES);
  localparam logic [LW-1:0] MAX_L       = LW'(MAX_LIVES);
  localparam logic [CW-1:0] DEATH_LAST  = CW'(DEATH_FRAMES - 1);
  localparam logic [CW-1:0] INVULN_LAST = CW'(INVULN_FRAMES - 1);

  life_state_t   state;
  logic [LW-1:0] lives;
  logic          last_life;
  logic          play_q;
  logic          respawn_r;
  logic          life_lost_r;
  logic          freeze_r;
  logic          invuln_r;
  logic          over_r;

  logic          play_rise;
  logic          timing;
  logic          timer_done;
  logic [CW-1:0] timer_last;
  logic [LW-1:0] hit_lives;
  logic          hit_last;

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v >= MAX_L) ? v : v + 1'b1;
  endfunction

  assign play_rise  = bus.playGame && !play_q;
  assign timing     = (state == INVULN) || (state == DYING);
  assign timer_last = (state == INVULN) ? INVULN_LAST : DEATH_LAST;

  // Hit resolved first, then a coincident bonus: on the last life the bonus cancels
  // the game-over instead of adding to the count.
  always_comb begin
    hit_lives = (lives != '0) ? lives - 1'b1 : '0;
    hit_last  = (lives == '0);
    if (bonus_in()) begin
      if (lives == '0) begin
        hit_last = 1'b0;
      end else begin
        hit_lives = sat_inc(hit_lives);
      end
    end
  end

  function automatic logic bonus_in();
    return bus.bonus_life;
  endfunction

  // Cleared whenever not in a timed state, so each timed state starts from zero
  // and a frame pulse coinciding with the entry edge is not counted.
  life_controller_frame_timer #(
    .CNT_W (CW)
  ) u_timer (
    .clk    (clk),
    .resetN (resetN),
    .clr    (!timing),
    .tick   (bus.startOfFrame && timing),
    .last   (timer_last),
    .done   (timer_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      lives       <= START_L;
      last_life   <= 1'b0;
      play_q      <= 1'b0;
      respawn_r   <= 1'b0;
      life_lost_r <= 1'b0;
      freeze_r    <= 1'b0;
      invuln_r    <= 1'b0;
      over_r      <= 1'b0;
    end else begin
      play_q      <= bus.playGame;
      respawn_r   <= 1'b0;
      life_lost_r <= 1'b0;
      case (state)
        IDLE: begin
          if (play_rise) begin
            lives     <= START_L;
            state     <= RESPAWN;
            respawn_r <= 1'b1;
          end
        end
        RESPAWN: begin
          if (bus.bonus_life) lives <= sat_inc(lives);
          state    <= INVULN;
          invuln_r <= 1'b1;
        end
        INVULN: begin
          if (bus.bonus_life) lives <= sat_inc(lives);
          if (timer_done) begin
            state    <= ALIVE;
            invuln_r <= 1'b0;
          end
        end
        ALIVE: begin
          if (bus.hit) begin
            lives       <= hit_lives;
            last_life   <= hit_last;
            life_lost_r <= 1'b1;
            freeze_r    <= 1'b1;
            state       <= DYING;
          end else if (bus.bonus_life) begin
            lives <= sat_inc(lives);
          end
        end
        DYING: begin
          if (bus.bonus_life) begin
            if (last_life) last_life <= 1'b0;
            else           lives     <= sat_inc(lives);
          end
          if (timer_done) begin
            freeze_r <= 1'b0;
            if (last_life && !bus.bonus_life) begin
              state  <= GAME_OVER;
              over_r <= 1'b1;
            end else begin
              state     <= RESPAWN;
              respawn_r <= 1'b1;
            end
          end
        end
        GAME_OVER: begin
          if (play_rise) begin
            last_life <= 1'b0;
            lives     <= START_L;
            over_r    <= 1'b0;
            state     <= RESPAWN;
            respawn_r <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          freeze_r <= 1'b0;
          invuln_r <= 1'b0;
          over_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lives_mask   = MAX_LIVES'(lives_to_mask(int'(lives)));
  assign bus.life_lost    = life_lost_r;
  assign bus.respawn      = respawn_r;
  assign bus.freeze       = freeze_r;
  assign bus.invulnerable = invuln_r;
  assign bus.game_over    = over_r;

endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller with START=3, MAX=3, DEATH=4, INVULN=3.
module tb_life_controller;

  localparam int DEATH  = 4;
  localparam int INVULN = 3;

  logic clk;
  logic resetN;
  int   n_vec;
  int   n_bad;

  life_controller_if #(.MAX_LIVES(3)) bus ();

  life_controller #(
    .START_LIVES   (3),
    .MAX_LIVES     (3),
    .DEATH_FRAMES  (DEATH),
    .INVULN_FRAMES (INVULN)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, then a frame pulse; returns just after the pulse's edge.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.startOfFrame = 1'b1;
      step();
      bus.startOfFrame = 1'b0;
    end
  endtask

  task automatic do_hit(input logic with_bonus);
    bus.hit        = 1'b1;
    bus.bonus_life = with_bonus;
    step();
    bus.hit        = 1'b0;
    bus.bonus_life = 1'b0;
  endtask

  task automatic recover(input string tag);
    frames(DEATH - 1);
    check_vec({tag, " freeze held"}, bus.freeze, 1);
    frames(1);
    check_vec({tag, " freeze drop"}, bus.freeze, 0);
    check_vec({tag, " respawn"}, bus.respawn, 1);
    step();
    check_vec({tag, " invuln on"}, bus.invulnerable, 1);
    frames(INVULN);
    check_vec({tag, " invuln off"}, bus.invulnerable, 0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    resetN           = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.playGame     = 1'b0;
    bus.hit          = 1'b0;
    bus.bonus_life   = 1'b0;
    #12;
    check_vec("rst mask", bus.lives_mask, 3'b111);
    check_vec("rst freeze", bus.freeze, 0);
    check_vec("rst over", bus.game_over, 0);
    check_vec("rst respawn", bus.respawn, 0);
    check_vec("rst invuln", bus.invulnerable, 0);
    resetN = 1'b1;
    step();
    step();

    // Start: respawn one cycle after the rise, then 3 invulnerable frames.
    bus.playGame = 1'b1;
    step();
    check_vec("start respawn", bus.respawn, 1);
    check_vec("start mask", bus.lives_mask, 3'b111);
    step();
    check_vec("respawn pulse end", bus.respawn, 0);
    check_vec("invuln entry", bus.invulnerable, 1);
    do_hit(1'b0);
    check_vec("invuln hit ignored", bus.life_lost, 0);
    check_vec("invuln hit mask", bus.lives_mask, 3'b111);
    frames(INVULN - 1);
    check_vec("invuln 2 frames", bus.invulnerable, 1);
    frames(1);
    check_vec("invuln done", bus.invulnerable, 0);

    // First hit, hit during DYING ignored.
    do_hit(1'b0);
    check_vec("hit1 lost", bus.life_lost, 1);
    check_vec("hit1 mask", bus.lives_mask, 3'b011);
    check_vec("hit1 freeze", bus.freeze, 1);
    step();
    check_vec("hit1 lost pulse", bus.life_lost, 0);
    do_hit(1'b0);
    check_vec("dying hit ignored", bus.life_lost, 0);
    check_vec("dying hit mask", bus.lives_mask, 3'b011);
    recover("hit1");

    do_hit(1'b0);
    check_vec("hit2 mask", bus.lives_mask, 3'b001);
    recover("hit2");
    do_hit(1'b0);
    check_vec("hit3 mask", bus.lives_mask, 3'b000);
    recover("hit3");
    do_hit(1'b0);
    check_vec("hit4 lost", bus.life_lost, 1);
    check_vec("hit4 mask", bus.lives_mask, 3'b000);
    frames(DEATH);
    check_vec("game over", bus.game_over, 1);
    check_vec("go no respawn", bus.respawn, 0);
    check_vec("go freeze", bus.freeze, 0);
    do_hit(1'b0);
    check_vec("go hit ignored", bus.life_lost, 0);
    bus.bonus_life = 1'b1;
    step();
    bus.bonus_life = 1'b0;
    check_vec("go bonus ignored", bus.lives_mask, 3'b000);

    // Restart from GAME_OVER.
    bus.playGame = 1'b0;
    step();
    bus.playGame = 1'b1;
    step();
    check_vec("restart respawn", bus.respawn, 1);
    check_vec("restart mask", bus.lives_mask, 3'b111);
    check_vec("restart over", bus.game_over, 0);
    step();
    frames(INVULN);
    bus.bonus_life = 1'b1;
    step();
    bus.bonus_life = 1'b0;
    check_vec("bonus saturates", bus.lives_mask, 3'b111);

    do_hit(1'b0);
    recover("to2");
    do_hit(1'b0);
    check_vec("at one life", bus.lives_mask, 3'b001);
    recover("to1");
    do_hit(1'b1);
    check_vec("hit+bonus mask", bus.lives_mask, 3'b001);
    check_vec("hit+bonus lost", bus.life_lost, 1);
    check_vec("hit+bonus freeze", bus.freeze, 1);
    frames(2);

    // Async reset mid-DYING.
    #2;
    resetN = 1'b0;
    #1;
    check_vec("async freeze", bus.freeze, 0);
    check_vec("async mask", bus.lives_mask, 3'b111);
    bus.playGame = 1'b0;
    #3;
    resetN = 1'b1;
    step();
    do_hit(1'b0);
    step();
    check_vec("idle respawn", bus.respawn, 0);
    check_vec("idle lost", bus.life_lost, 0);
    check_vec("idle invuln", bus.invulnerable, 0);
    bus.playGame = 1'b1;
    step();
    check_vec("post-reset respawn", bus.respawn, 1);
    step();
    frames(INVULN);

    // Down to zero spare lives, then hit+bonus keeps the game alive.
    do_hit(1'b0);
    recover("z2");
    do_hit(1'b0);
    recover("z1");
    do_hit(1'b0);
    check_vec("zero mask", bus.lives_mask, 3'b000);
    recover("z0");
    do_hit(1'b1);
    check_vec("last hit+bonus lost", bus.life_lost, 1);
    check_vec("last hit+bonus mask", bus.lives_mask, 3'b000);
    frames(DEATH);
    check_vec("last hit+bonus respawn", bus.respawn, 1);
    check_vec("last hit+bonus no over", bus.game_over, 0);
    step();
    frames(INVULN);

    // Bonus during the final DYING rescues the player.
    do_hit(1'b0);
    step();
    bus.bonus_life = 1'b1;
    step();
    bus.bonus_life = 1'b0;
    check_vec("dying bonus mask", bus.lives_mask, 3'b000);
    frames(DEATH);
    check_vec("dying bonus respawn", bus.respawn, 1);
    check_vec("dying bonus no over", bus.game_over, 0);
    step();
    frames(INVULN);
    do_hit(1'b0);
    frames(DEATH);
    check_vec("final over", bus.game_over, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
